// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) responder with a 16-bit register-address bus.
//  Oversamples SCL/SDA on clk, decodes START/STOP/address/data and answers
//  SLAVE_ADDR. SDA is driven only via an open-drain pull-low enable.
// Ports:
//  clk       system clock (>=20x SCL)
//  areset_n  asynchronous active-low reset
//  scl_di    SCL pad input (async)
//  sda_di    SDA pad input (async)
//  sda_oe    1 = pull SDA low
//  reg_addr  current register address, auto-increments after each data byte
//  reg_wdata write data, valid with reg_we
//  reg_we    1-clk write strobe
//  reg_re    1-clk read strobe; reg_rdata sampled on the next clk
//  reg_rdata read data
//  busy      1 from address match until STOP or START
module i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'd16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        scl_di,
  input  logic        sda_di,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_RA_HI, S_ACK_H, S_RA_LO, S_ACK_L,
    S_WR, S_ACK_W, S_RD, S_MACK
  } state_t;

  // One flop beyond the synchronizer keeps the previous sample for edge detection.
  logic [SYNC_STAGES:0] r_scl_sync, r_sda_sync;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-1:0], scl_di};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-1:0], sda_di};
    end
  end

  logic w_scl_cur, w_scl_prev, w_sda_cur, w_sda_prev;
  logic w_start, w_stop, w_rise, w_fall;
  assign w_scl_cur  = r_scl_sync[SYNC_STAGES-1];
  assign w_scl_prev = r_scl_sync[SYNC_STAGES];
  assign w_sda_cur  = r_sda_sync[SYNC_STAGES-1];
  assign w_sda_prev = r_sda_sync[SYNC_STAGES];
  assign w_start = w_scl_cur & w_scl_prev &  w_sda_prev & ~w_sda_cur;
  assign w_stop  = w_scl_cur & w_scl_prev & ~w_sda_prev &  w_sda_cur;
  assign w_rise  = ~w_scl_prev &  w_scl_cur;
  assign w_fall  =  w_scl_prev & ~w_scl_cur;

  state_t      r_state;
  logic [3:0]  r_cnt;    // SCL rises seen in the current byte
  logic [7:0]  r_sr;     // receive shift reg, or transmit shift reg in RD
  logic [7:0]  r_ahi;
  logic        r_rw, r_mack, r_drive;
  logic        r_oe, r_we, r_re, r_busy;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_ahi   <= '0;
      r_rw    <= 1'b0;
      r_mack  <= 1'b1;
      r_drive <= 1'b0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      if (r_we) r_addr <= r_addr + 16'd1;
      // Read pipeline: strobe -> capture rdata -> drive MSB.
      if (r_re) begin
        r_sr    <= reg_rdata;
        r_drive <= 1'b1;
      end
      if (r_drive) begin
        r_oe    <= ~r_sr[7];
        r_drive <= 1'b0;
      end
      // START/STOP take priority over any SCL edge in the same clk.
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
        r_drive <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
        r_drive <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_ADDR, S_RA_HI, S_RA_LO, S_WR: begin
            if (w_rise && r_cnt < 4'd8) begin
              r_sr  <= {r_sr[6:0], w_sda_cur};
              r_cnt <= r_cnt + 4'd1;
            end else if (w_fall && r_cnt == 4'd8) begin
              r_cnt <= '0;
              r_oe  <= 1'b1;
              case (r_state)
                S_ADDR: begin
                  // General call (address 0) is never acknowledged.
                  if (r_sr[7:1] == SLAVE_ADDR && r_sr[7:1] != 7'd0) begin
                    r_busy  <= 1'b1;
                    r_rw    <= r_sr[0];
                    r_state <= S_ACK_A;
                  end else begin
                    r_oe    <= 1'b0;
                    r_state <= S_IDLE;
                  end
                end
                S_RA_HI: begin
                  r_ahi   <= r_sr;
                  r_state <= S_ACK_H;
                end
                S_RA_LO: r_state <= S_ACK_L;
                default: begin
                  r_we    <= 1'b1;
                  r_wdata <= r_sr;
                  r_state <= S_ACK_W;
                end
              endcase
            end
          end
          S_ACK_A: if (w_fall) begin
            r_oe  <= 1'b0;
            r_cnt <= '0;
            if (r_rw) begin
              r_re    <= 1'b1;
              r_state <= S_RD;
            end else begin
              r_state <= S_RA_HI;
            end
          end
          S_ACK_H: if (w_fall) begin
            r_oe    <= 1'b0;
            r_state <= S_RA_LO;
          end
          S_ACK_L: if (w_fall) begin
            r_oe    <= 1'b0;
            r_addr  <= {r_ahi, r_sr};
            r_state <= S_WR;
          end
          S_ACK_W: if (w_fall) begin
            r_oe    <= 1'b0;
            r_state <= S_WR;
          end
          S_RD: begin
            if (w_rise && r_cnt < 4'd8) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_fall && r_cnt == 4'd8) begin
              r_oe    <= 1'b0;
              r_addr  <= r_addr + 16'd1;
              r_state <= S_MACK;
            end else if (w_fall && r_cnt != 4'd0) begin
              r_sr <= {r_sr[6:0], 1'b0};
              r_oe <= ~r_sr[6];
            end
          end
          S_MACK: begin
            if (w_rise) begin
              r_mack <= w_sda_cur;
            end else if (w_fall) begin
              r_cnt <= '0;
              if (!r_mack) begin
                r_re    <= 1'b1;
                r_state <= S_RD;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe    = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bench for i2c_target. An I2C master model drives the wired-AND
// bus; a transaction-level model tracks the register pointer, expected writes,
// read data and ACKs.
module tb_i2c_target;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        m_scl = 1'b1, m_sda = 1'b1;
  logic [7:0]  rd_key = 8'h00;
  logic        sda_oe, reg_we, reg_re, busy;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;
  wire         sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  assign reg_rdata = reg_addr[7:0] ^ rd_key;

  i2c_target #(.SLAVE_ADDR(7'd16), .SYNC_STAGES(2)) dut (
    .clk(clk), .areset_n(areset_n), .scl_di(m_scl), .sda_di(sda_bus),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- bus monitor ----
  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         we_q[$];
  int          re_cnt = 0;
  bit          oe_seen = 0;
  logic        prev_oe = 1'b0;
  bit          pend_we = 0;
  logic [15:0] pend_nx;

  always @(negedge clk) begin
    if (pend_we) begin
      chk("addr_inc_after_we", reg_addr, pend_nx);
      pend_we = 0;
    end
    if (reg_we) begin
      we_q.push_back('{reg_addr, reg_wdata});
      pend_we = 1;
      pend_nx = reg_addr + 16'd1;
    end
    if (reg_re) re_cnt++;
    if (sda_oe) oe_seen = 1;
    if (areset_n && sda_oe !== prev_oe) chk("oe_change_while_scl_low", m_scl, 0);
    prev_oe = sda_oe;
  end

  // ---- master model ----
  task automatic q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b; q(); m_scl = 1'b1; q(); s = sda_bus; q(); m_scl = 1'b0; q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // ---- transaction-level reference ----
  typedef struct {
    bit               rd;
    logic [7:0]       dev;
    logic [15:0]      ra;
    int               n;
    logic [3:0][7:0]  d;
    bit               sr;        // end with repeated START instead of STOP
    int               exp_acks;
    int               exp_we;
  } txn_t;

  logic [15:0] m_addr = 16'h0000;

  function automatic logic [7:0] rd_exp(input logic [15:0] a);
    return a[7:0] ^ rd_key;
  endfunction

  task automatic run_txn(input txn_t t);
    logic        a, match;
    logic [7:0]  d;
    int          acks, we0, re0, nexp;
    logic [15:0] ea[4];
    logic [7:0]  ed[4];
    acks = 0; nexp = 0;
    we0 = we_q.size(); re0 = re_cnt;
    match = (t.dev[7:1] == 7'd16);
    oe_seen = 0;
    i2c_start();
    wr_byte(t.dev, a); acks += int'(a);
    chk("addr_ack", a, match);
    chk("busy_after_addr", busy, match);
    if (!t.rd) begin
      wr_byte(t.ra[15:8], a); acks += int'(a);
      wr_byte(t.ra[7:0], a);  acks += int'(a);
      if (match) m_addr = t.ra;
      for (int i = 0; i < t.n; i++) begin
        wr_byte(t.d[i], a); acks += int'(a);
        if (match) begin
          ea[nexp] = m_addr; ed[nexp] = t.d[i]; nexp++;
          m_addr = m_addr + 16'd1;
        end
      end
    end else begin
      for (int i = 0; i < t.n; i++) begin
        rd_byte(i == t.n - 1, d);
        chk("read_byte", d, rd_exp(m_addr));
        m_addr = m_addr + 16'd1;
      end
    end
    if (!t.sr) begin
      i2c_stop();
      q();
      chk("busy_after_stop", busy, 0);
    end
    chk("ack_count", acks, t.exp_acks);
    chk("we_count", we_q.size() - we0, t.exp_we);
    for (int i = 0; i < nexp; i++) begin
      if (we0 + i < we_q.size()) begin
        chk("we_addr", we_q[we0+i].a, ea[i]);
        chk("we_data", we_q[we0+i].d, ed[i]);
      end
    end
    chk("re_count", re_cnt - re0, (t.rd && match) ? t.n : 0);
    chk("oe_seen", oe_seen, match);
    chk("reg_addr", reg_addr, m_addr);
  endtask

  txn_t tbl[5];
  txn_t t;
  logic a;
  int   w5;

  initial begin
    tbl[0] = '{rd:0, dev:8'h20, ra:16'h300A, n:2, d:{8'h00,8'h00,8'h5A,8'hA5}, sr:0, exp_acks:5, exp_we:2};
    tbl[1] = '{rd:0, dev:8'h20, ra:16'h1234, n:0, d:'0, sr:1, exp_acks:3, exp_we:0};
    tbl[2] = '{rd:1, dev:8'h21, ra:16'h0000, n:2, d:'0, sr:0, exp_acks:1, exp_we:0};
    tbl[3] = '{rd:0, dev:8'h22, ra:16'hC3A5, n:1, d:{8'h00,8'h00,8'h00,8'h3C}, sr:0, exp_acks:0, exp_we:0};
    tbl[4] = '{rd:0, dev:8'h20, ra:16'hFFFF, n:2, d:{8'h00,8'h00,8'h22,8'h11}, sr:0, exp_acks:5, exp_we:2};

    // reset state
    areset_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_busy", busy, 0);
    areset_n = 1'b1;
    q();

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // START injected mid-byte aborts it; retry writes once
    w5 = we_q.size();
    i2c_start();
    wr_byte(8'h20, a); chk("t5_ack_dev", a, 1);
    wr_byte(8'h00, a);
    wr_byte(8'h01, a);
    m_addr = 16'h0001;
    clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a); clk_bit(1'b1, a);
    t = '{rd:0, dev:8'h20, ra:16'h0001, n:1, d:{8'h00,8'h00,8'h00,8'hFE}, sr:0, exp_acks:4, exp_we:1};
    run_txn(t);
    chk("t5_we_total", we_q.size() - w5, 1);

    // reset mid-read while driving MSB=0, then a normal transaction
    i2c_start();
    wr_byte(8'h20, a);
    wr_byte(8'h00, a);
    wr_byte(8'h10, a);
    i2c_start();
    wr_byte(8'h21, a);
    chk("t6_rd_ack", a, 1);
    chk("t6_drive_msb0", sda_oe, 1);
    areset_n = 1'b0;
    #1;
    chk("t6_rst_oe", sda_oe, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", reg_addr, 0);
    m_addr = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    areset_n = 1'b1;
    i2c_stop();
    q();
    t = '{rd:0, dev:8'h20, ra:16'h0042, n:1, d:{8'h00,8'h00,8'h00,8'h77}, sr:0, exp_acks:4, exp_we:1};
    run_txn(t);

    // randomized transactions against the model
    rd_key = 8'h00;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] x;
      rd_key = 8'($urandom);
      t.rd = ($urandom_range(0, 2) == 0);
      if (!t.rd && $urandom_range(0, 4) == 0) begin
        do x = 8'($urandom); while (x[7:1] == 7'd16);
        t.dev = {x[7:1], 1'b0};
      end else begin
        t.dev = {7'd16, t.rd};
      end
      t.ra = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      t.n  = t.rd ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      t.d  = 32'($urandom);
      t.sr = 0;
      t.exp_acks = (t.dev[7:1] != 7'd16) ? 0 : (t.rd ? 1 : 3 + t.n);
      t.exp_we   = (t.dev[7:1] == 7'd16 && !t.rd) ? t.n : 0;
      run_txn(t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
